// File: rtl/mult8_seq_sched.sv
// Sequential WxW unsigned multiplier that time-shares one external (W/2)x(W/2) multiplier
// over four cycles (LL, LH, HL, HH), shift-accumulating the partial products.
module mult8_seq_sched #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             busy,
  output logic [W/2-1:0]   mul_a,
  output logic [W/2-1:0]   mul_b,
  input  logic [W-1:0]     mul_p
);

  localparam int H = W / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LL,
    S_LH,
    S_HL,
    S_HH,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_ra;
  logic [W-1:0]     r_rb;
  logic [2*W-1:0]   r_acc;

  logic [2*W-1:0]   w_mul_ext;
  logic [2*W-1:0]   w_addend;

  assign w_mul_ext = {{W{1'b0}}, mul_p};

  // Weight of the current partial product: LL x1, cross terms x2^H, HH x2^2H.
  always_comb begin
    w_addend = '0;
    case (r_state)
      S_LL:       w_addend = w_mul_ext;
      S_LH, S_HL: w_addend = w_mul_ext << H;
      S_HH:       w_addend = w_mul_ext << (2 * H);
      default:    w_addend = '0;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (r_state)
      S_LL: begin mul_a = r_ra[H-1:0]; mul_b = r_rb[H-1:0]; end
      S_LH: begin mul_a = r_ra[H-1:0]; mul_b = r_rb[W-1:H]; end
      S_HL: begin mul_a = r_ra[W-1:H]; mul_b = r_rb[H-1:0]; end
      S_HH: begin mul_a = r_ra[W-1:H]; mul_b = r_rb[W-1:H]; end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ra    <= a;
            r_rb    <= b;
            r_acc   <= '0;
            r_state <= S_LL;
          end
        end
        S_LL: begin
          r_acc   <= r_acc + w_addend;
          r_state <= S_LH;
        end
        S_LH: begin
          r_acc   <= r_acc + w_addend;
          r_state <= S_HL;
        end
        S_HL: begin
          r_acc   <= r_acc + w_addend;
          r_state <= S_HH;
        end
        S_HH: begin
          r_acc   <= r_acc + w_addend;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign p         = r_acc;

endmodule
